// File: rtl/intc.sv
// Level-to-edge interrupt controller with four CPU-mapped registers (PEND, MASK, ID, CTRL).
// Define INTC_SYNC_EN to pass i_irq through a ce-gated 2-flop synchronizer before edge detection.
module intc #(
   parameter logic [15:0] BASE_ADDR = 16'hFFF0,
   parameter int          NUM_IRQ   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ce,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic [15:0]        i_mem_write_addr,
   input  logic [15:0]        i_mem_write_data,
   input  logic               i_ram_we,
   input  logic [15:0]        i_mem_read_addr,
   output logic [15:0]        o_read_data,
   output logic               o_sel,
   output logic               o_int
);

   localparam logic [15:0] IMPL_BITS = 16'((17'd1 << NUM_IRQ) - 17'd1);

   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] prev_q;
   logic [15:0]        pending_q, pending_d;
   logic [15:0]        mask_q, mask_d;
   logic               gen_q, gen_d;
   logic [15:0]        edge_v;
   logic [15:0]        act;
   logic [3:0]         id_idx;
   logic [15:0]        wr_off, rd_off;
   logic               wr_hit;

`ifdef INTC_SYNC_EN
   logic [NUM_IRQ-1:0] sync1_q, sync2_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else if (i_ce) begin
         sync1_q <= i_irq;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = i_irq;
`endif

   // Offsets use wrapping subtraction so the window works anywhere in the map.
   assign wr_off = i_mem_write_addr - BASE_ADDR;
   assign rd_off = i_mem_read_addr - BASE_ADDR;
   assign wr_hit = i_ram_we && (wr_off[15:2] == 14'd0);
   assign o_sel  = (rd_off[15:2] == 14'd0);

   assign edge_v = 16'(irq_s & ~prev_q);
   assign act    = pending_q & mask_q;

   always_comb begin
      pending_d = pending_q;
      mask_d    = mask_q;
      gen_d     = gen_q;
      if (wr_hit) begin
         case (wr_off[1:0])
            2'd0:    pending_d = pending_q & ~i_mem_write_data;
            2'd1:    mask_d    = i_mem_write_data & IMPL_BITS;
            2'd3:    gen_d     = i_mem_write_data[0];
            default: ;
         endcase
      end
      // A new edge wins over a same-cycle W1C.
      pending_d = (pending_d | edge_v) & IMPL_BITS;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prev_q    <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         gen_q     <= 1'b0;
      end else if (i_ce) begin
         prev_q    <= irq_s;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         gen_q     <= gen_d;
      end
   end

   always_comb begin
      id_idx = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (act[i]) id_idx = 4'(i);
      end
   end

   always_comb begin
      o_read_data = 16'h0000;
      if (o_sel) begin
         case (rd_off[1:0])
            2'd0: o_read_data = pending_q;
            2'd1: o_read_data = mask_q;
            2'd2: o_read_data = {(|act), 11'd0, id_idx};
            2'd3: o_read_data = {15'd0, gen_q};
         endcase
      end
   end

   assign o_int = gen_q & (|act);

endmodule
